// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: valid/ready input FIFO feeding an 8-bit
// LSB-first serialiser with start bit, optional parity bit and one stop bit.
module uart_tx #(
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned CLOCK_FREQ   = 12_000_000,
    parameter int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]      CNT_DEC  = 16'd1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]       IDX_LAST = 3'd7;
    localparam logic [2:0]       IDX_ONE  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [7:0]       head;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign ready = (count != CNT_FULL);
    assign push  = valid && ready;
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    state_t      state;
    state_t      state_n;
    logic [15:0] baud_cnt;
    logic [15:0] cnt_n;
    logic [2:0]  bit_idx;
    logic [2:0]  idx_n;
    logic [2:0]  idx_inc;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_n;
    logic        tx_q;
    logic        tx_n;
    logic        bit_end;
    logic        par_bit;

    assign bit_end = (baud_cnt == 16'd0);
    assign idx_inc = bit_idx + IDX_ONE;
    assign par_bit = (PARITY == 2) ? ~^shift_reg : ^shift_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= cnt_n;
            bit_idx   <= idx_n;
            shift_reg <= shift_n;
            tx_q      <= tx_n;
        end
    end

    // tx_n is the line level for the cycle after this edge, so the
    // registered output only ever moves on a bit boundary.
    always_comb begin
        state_n = state;
        cnt_n   = baud_cnt;
        idx_n   = bit_idx;
        shift_n = shift_reg;
        tx_n    = tx_q;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                tx_n  = 1'b1;
                cnt_n = 16'd0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    cnt_n   = BIT_LAST;
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = 3'd0;
                    cnt_n   = BIT_LAST;
                    tx_n    = shift_reg[0];
                end else begin
                    cnt_n = baud_cnt - CNT_DEC;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n = BIT_LAST;
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n = idx_inc;
                        tx_n  = shift_reg[idx_inc];
                    end
                end else begin
                    cnt_n = baud_cnt - CNT_DEC;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cnt_n   = BIT_LAST;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = baud_cnt - CNT_DEC;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        cnt_n   = BIT_LAST;
                        state_n = S_START;
                        tx_n    = 1'b0;
                    end else begin
                        cnt_n   = 16'd0;
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = baud_cnt - CNT_DEC;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 16'd0;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/even/odd parity) on shared inputs,
// a line decoder per instance and a byte scoreboard built from handshakes.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic [2:0] ready;
    logic [2:0] tx;
    logic [2:0] busy;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY(0), .FIFO_DEPTH(4)) u_none (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0])
    );
    uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1])
    );
    uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY(2), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2])
    );

    typedef struct {
        logic [7:0] b;
        logic       sbit;
        logic       pbit;
        logic       stop;
        int         start;
    } rx_t;

    typedef struct {
        logic [7:0] b;
        logic       pe;
        logic       po;
    } vec_t;

    rx_t        rxq [3][$];
    logic [7:0] expq[3][$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         falls[3] = '{0, 0, 0};
    logic [2:0] prev_tx = 3'b111;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait expired (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard: every handshake a given instance accepts is owed on its line.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int k = 0; k < 3; k++) expq[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (valid && ready[k]) expq[k].push_back(data);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (prev_tx[k] === 1'b1 && tx[k] === 1'b0) falls[k]++;
            prev_tx[k] = tx[k];
        end
    end

    // Receiver: find the start edge, then sample each bit at its middle.
    task automatic monitor(input int k);
        logic prev;
        rx_t  r;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx[k] === 1'b0) begin
                r.start = cyc;
                r.pbit  = 1'b0;
                repeat (7) @(negedge clk);
                r.sbit = tx[k];
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    r.b[i] = tx[k];
                end
                if (k != 0) begin
                    repeat (16) @(negedge clk);
                    r.pbit = tx[k];
                end
                repeat (16) @(negedge clk);
                r.stop = tx[k];
                rxq[k].push_back(r);
            end
            prev = tx[k];
        end
    endtask

    task automatic send(input logic [7:0] b, input int budget, output int acc);
        data  = b;
        valid = 1'b1;
        acc   = -1;
        for (int i = 0; i < budget; i++) begin
            if (ready[0]) begin
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) timeout("send");
    endtask

    task automatic wait_idle(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 3'b000) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok == 0) timeout("wait_idle");
        repeat (20) @(negedge clk);
    endtask

    task automatic drain_check(input int k, input int gap);
        int         prev;
        rx_t        r;
        logic [7:0] e;
        logic       pexp;
        prev = -1;
        check($sformatf("rx_count%0d", k), rxq[k].size(), expq[k].size());
        while (rxq[k].size() > 0 && expq[k].size() > 0) begin
            r = rxq[k].pop_front();
            e = expq[k].pop_front();
            check($sformatf("rx_byte%0d", k), r.b, e);
            check($sformatf("rx_startbit%0d", k), r.sbit, 0);
            check($sformatf("rx_stopbit%0d", k), r.stop, 1);
            if (k != 0) begin
                pexp = (($countones(e) % 2) == 1) ^ (k == 2);
                check($sformatf("rx_parity%0d", k), r.pbit, pexp);
            end
            if (gap > 0 && prev >= 0) check($sformatf("rx_gap%0d", k), r.start - prev, gap);
            prev = r.start;
        end
        rxq[k].delete();
        expq[k].delete();
    endtask

    initial begin
        vec_t       tbl[6];
        logic [9:0] a5_line;
        logic [7:0] fb[5];
        int         accs[6];
        int         acc;
        int         f0;
        rx_t        r;
        logic       pexp;

        tbl[0] = '{8'h07, 1'b1, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 1'b1, 1'b0};
        tbl[5] = '{8'h5B, 1'b1, 1'b0};
        a5_line = 10'b11_0100_1010;
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        reset = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tx%0d", k), tx[k], 1);
            check($sformatf("rst_ready%0d", k), ready[k], 1);
            check($sformatf("rst_busy%0d", k), busy[k], 0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Single 0xA5 frame: latency, line pattern and busy fall.
        check("a5_ready", ready[0], 1);
        data  = 8'hA5;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("a5_busy_after_accept", busy[0], 1);
        check("a5_tx_still_idle", tx[0], 1);
        @(negedge clk);
        check("a5_tx_fall", tx[0], 0);
        repeat (7) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("a5_line_bit%0d", j), tx[0], a5_line[j]);
            if (j < 9) repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("a5_busy_last_stop", busy[0], 1);
        @(negedge clk);
        check("a5_busy_fall", busy[0], 0);
        check("a5_tx_idle", tx[0], 1);
        wait_idle(1000);
        for (int k = 0; k < 3; k++) drain_check(k, 0);

        // Table of bytes with hand-computed parity bits.
        for (int v = 0; v < 6; v++) begin
            send(tbl[v].b, 50, acc);
            valid = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (rxq[0].size() > 0 && rxq[1].size() > 0 && rxq[2].size() > 0) break;
                @(negedge clk);
            end
            for (int k = 0; k < 3; k++) begin
                if (rxq[k].size() == 0) begin
                    timeout($sformatf("tbl_rx%0d_%0d", k, v));
                end else begin
                    r = rxq[k].pop_front();
                    if (expq[k].size() > 0) void'(expq[k].pop_front());
                    check($sformatf("tbl_byte%0d_%0d", k, v), r.b, tbl[v].b);
                    check($sformatf("tbl_stop%0d_%0d", k, v), r.stop, 1);
                    if (k != 0) begin
                        pexp = (k == 1) ? tbl[v].pe : tbl[v].po;
                        check($sformatf("tbl_parity%0d_%0d", k, v), r.pbit, pexp);
                    end
                end
            end
        end
        wait_idle(1000);
        for (int k = 0; k < 3; k++) drain_check(k, 0);

        // FIFO fill: five pushes back to back, then a sixth held against full.
        for (int i = 0; i < 5; i++) send(fb[i], 50, accs[i]);
        check("full_consecutive", accs[4] - accs[0], 4);
        check("full_ready_low", ready[0], 0);
        send(8'h66, 400, accs[5]);
        valid = 1'b0;
        check("collide_accept_delay", accs[5] - accs[0], 162);
        check("refill_ready_low", ready[0], 0);
        wait_idle(3000);
        drain_check(0, 160);
        drain_check(1, 176);
        drain_check(2, 176);

        // Reset during bit 3 of 0x3C with two bytes queued.
        send(8'h3C, 50, acc);
        send(8'h01, 50, acc);
        send(8'h02, 50, acc);
        valid = 1'b0;
        repeat (69) @(negedge clk);
        check("mid_busy_before", busy[0], 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_tx", tx[0], 1);
        check("mid_busy", busy[0], 0);
        check("mid_ready", ready[0], 1);
        check("mid_busy_par", busy[2:1], 2'b00);
        @(negedge clk);
        reset = 1'b1;
        f0 = falls[0];
        repeat (300) @(negedge clk);
        check("mid_no_frames", falls[0], f0);
        check("mid_idle_busy", busy[0], 0);
        check("mid_idle_tx", tx[0], 1);
        for (int k = 0; k < 3; k++) begin
            rxq[k].delete();
            expq[k].delete();
        end

        // Random bytes with random gaps against the scoreboard.
        for (int n = 0; n < 24; n++) begin
            valid = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(8'($urandom), 400, acc);
        end
        valid = 1'b0;
        wait_idle(8000);
        for (int k = 0; k < 3; k++) drain_check(k, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
